// File: rtl/mem_stage_if.sv
// Data-memory port of the memory-access stage.
// Request fields are driven by the stage; read data and ack by memory.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute result, runs one
// data-memory access with bounded wait states, formats loads, retires.
module mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_aluResult,
    input  logic [31:0] ex_storeData,
    input  logic [4:0]  ex_destReg,
    input  logic        ex_RegWrite,
    input  logic        ex_MemToReg,
    input  logic        ex_MemWrite,
    input  logic        ex_loadSign,
    input  logic [1:0]  ex_DSize,
    output logic        mem_stall,
    mem_stage_if.master dmem,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_destReg,
    output logic [31:0] wb_data,
    output logic        wb_fault,
    output logic        wb_timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  dest;
        logic        rw;
        logic        m2r;
        logic        mw;
        logic        ls;
        logic [1:0]  sz;
    } m_t;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    m_t          r_m;
    state_t      r_state;
    state_t      w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    logic [1:0]  w_off;
    logic        w_memop;
    logic        w_mis;
    logic        w_req;
    logic        w_timeout;
    logic        w_stall;
    logic        w_fault;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_off   = r_m.alu[1:0];
    assign w_memop = r_m.m2r | r_m.mw;

    // Alignment: halfword needs even address, word (10/11) needs 4-byte.
    always_comb begin
        w_mis = 1'b0;
        unique case (r_m.sz)
            2'b00:   w_mis = 1'b0;
            2'b01:   w_mis = w_off[0];
            default: w_mis = |w_off;
        endcase
    end

    // FSM state register and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: stay in WAIT while stalled, counting elapsed cycles.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_stall) begin
                    w_next     = S_WAIT;
                    w_cnt_next = CW'(1);
                end
            end
            S_WAIT: begin
                if (w_stall) begin
                    w_cnt_next = r_cnt + CW'(1);
                end else begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // FSM outputs; an ack in the last permitted cycle beats the timeout.
    always_comb begin
        w_req = 1'b0;
        unique case (r_state)
            S_IDLE:  w_req = r_m.valid & w_memop & ~w_mis;
            S_WAIT:  w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
        w_timeout = w_req & ~dmem.dmem_ack & (r_cnt == LAST);
        w_stall   = w_req & ~dmem.dmem_ack & ~w_timeout;
    end

    // Store lane replication and byte enables (lane 3 = offset 0).
    always_comb begin
        w_wdata = r_m.sdata;
        w_be    = 4'b1111;
        unique case (r_m.sz)
            2'b00: begin
                w_wdata = {4{r_m.sdata[7:0]}};
                w_be    = 4'b1000 >> w_off;
            end
            2'b01: begin
                w_wdata = {2{r_m.sdata[15:0]}};
                w_be    = w_off[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                w_wdata = r_m.sdata;
                w_be    = 4'b1111;
            end
        endcase
    end

    // Load lane select, right-justify and extend.
    always_comb begin
        w_byte = dmem.dmem_rdata[31:24];
        unique case (w_off)
            2'd0: w_byte = dmem.dmem_rdata[31:24];
            2'd1: w_byte = dmem.dmem_rdata[23:16];
            2'd2: w_byte = dmem.dmem_rdata[15:8];
            2'd3: w_byte = dmem.dmem_rdata[7:0];
        endcase
        w_half = w_off[1] ? dmem.dmem_rdata[15:0] : dmem.dmem_rdata[31:16];
        unique case (r_m.sz)
            2'b00:   w_load = {{24{r_m.ls & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_m.ls & w_half[15]}}, w_half};
            default: w_load = dmem.dmem_rdata;
        endcase
    end

    assign w_fault = (w_memop & w_mis) | w_timeout;

    assign mem_stall       = w_stall;
    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = w_req & r_m.mw;
    assign dmem.dmem_addr  = w_req ? {r_m.alu[31:2], 2'b00} : 32'd0;
    assign dmem.dmem_wdata = w_req ? w_wdata : 32'd0;
    assign dmem.dmem_be    = w_req ? w_be : 4'b0000;

    // Stage register: holds the instruction while its access is pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m <= '0;
        end else if (!w_stall) begin
            r_m <= '{valid: ex_valid, alu: ex_aluResult,
                     sdata: ex_storeData, dest: ex_destReg,
                     rw: ex_RegWrite, m2r: ex_MemToReg,
                     mw: ex_MemWrite, ls: ex_loadSign, sz: ex_DSize};
        end
    end

    // Writeback register: retire once the stage is no longer stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_destReg  <= '0;
            wb_data     <= '0;
            wb_fault    <= 1'b0;
            wb_timeout  <= 1'b0;
        end else if (r_m.valid && !w_stall) begin
            wb_valid    <= 1'b1;
            wb_RegWrite <= r_m.rw & ~w_fault;
            wb_destReg  <= r_m.dest;
            wb_data     <= r_m.m2r ? w_load : r_m.alu;
            wb_fault    <= w_fault;
            wb_timeout  <= w_timeout;
        end else begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline: the downstream consumer of everything the execute stage produces. Latches the execute result, performs loads and stores on the data-memory port with a req/ack handshake and bounded wait states, formats load data by size and sign, and presents a registered result to writeback. Stalls upstream while an access is outstanding and reports misaligned or timed-out accesses.

## Interface
- MAX_WAIT, 15: cycles a request may stay unacknowledged before it is abandoned (≥1).
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- ex_valid  in  1  execute stage presents an instruction this cycle.
- ex_aluResult  in  32  ALU result; the effective address for memory ops.
- ex_storeData  in  32  store operand (opB path).
- ex_destReg  in  5  destination register.
- ex_RegWrite, ex_MemToReg, ex_MemWrite, ex_loadSign  in  1 each  control bits carried from decode.
- ex_DSize  in  2  00 byte, 01 halfword, 11 word; 10 treated as word.
- mem_stall  out  1  execute must hold its outputs; stage register does not load.
- dmem_req  out  1  access request; held until ack or timeout.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address (low two bits forced 0).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables; bit 3 = most-significant byte lane (byte offset 0, big-endian).
- dmem_rdata  in  32  read data, valid when dmem_ack.
- dmem_ack  in  1  access complete this cycle.
- wb_valid  out  1  writeback register holds a retired instruction.
- wb_RegWrite  out  1  register-file write enable.
- wb_destReg  out  5  destination register.
- wb_data  out  32  formatted load data or ALU result.
- wb_fault  out  1  retired instruction faulted (misaligned or timeout).
- wb_timeout  out  1  qualifies wb_fault: 1 = timeout, 0 = misaligned.

## Operation
- Stage register M loads ex_* on every edge where mem_stall = 0; M.valid <= ex_valid.
- Memory op = M.MemToReg | M.MemWrite. Misaligned: halfword with addr[0]=1, word with addr[1:0]≠00; misaligned ops never assert dmem_req.
- FSM IDLE/WAIT. In IDLE, dmem_req = M.valid & memop & aligned. Ack in the same cycle completes the access; no ack → WAIT, wait counter = 1.
- In WAIT: dmem_req held; addr/we/be/wdata stable. Ack → complete, IDLE. Counter reaching MAX_WAIT without ack → drop req, retire as timeout fault, IDLE. Ack arriving in the timeout cycle wins.
- mem_stall = dmem_req & ~dmem_ack & ~timeout.
- Store lanes: byte replicated to all four lanes, be = one-hot by offset (00→1000 … 11→0001); halfword replicated to both halves, be = 1100 / 0011; word be = 1111.
- Load: select byte/halfword lane by offset, right-justify, zero-extend, or sign-extend when loadSign = 1. Word passes unchanged.
- Retire (writeback register load) on edge where M.valid & ~mem_stall: wb_data = formatted load if MemToReg else aluResult; wb_RegWrite = M.RegWrite & ~fault; wb_fault/wb_timeout as applicable. Otherwise wb_valid <= 0 and wb_RegWrite <= 0.

## Timing
- Reset: all outputs 0, M.valid 0, FSM IDLE, counter 0; dmem_req falls asynchronously even mid-access.
- Non-memory op and zero-wait memory op: M→WB latency 1 cycle, no stall.
- N wait states (N < MAX_WAIT): mem_stall high N cycles; retire on the ack edge.
- Timeout: req high exactly MAX_WAIT cycles, stall MAX_WAIT−1 cycles; fault retires on the next edge.
- Misaligned: no req, no stall, fault retires after 1 cycle.
- Bubble (ex_valid = 0) produces wb_valid = 0 next cycle; back-to-back instructions retire every cycle absent stalls.

## Test plan
- Reset with ex_valid=1 held → all outputs 0; after release an ALU op aluResult=0x12345678, destReg=5, RegWrite=1 → next cycle wb_valid=1, wb_data=0x12345678, wb_destReg=5.
- Signed byte load addr=0x103, rdata=0x000000F0, ack same cycle → dmem_addr=0x100, be=0001, no stall, wb_data=0xFFFFFFF0; with loadSign=0 → 0x000000F0.
- Halfword store addr=0x202, storeData=0x0000ABCD, ack after 3 cycles → wdata=0xABCDABCD, be=0011, mem_stall high 3 cycles, request fields stable throughout.
- Word load addr=0x401 → no dmem_req, next cycle wb_fault=1, wb_timeout=0, wb_RegWrite=0.
- Word load, ack never arrives, MAX_WAIT=15 → req high 15 cycles, then wb_fault=1, wb_timeout=1; next queued instruction retires the following cycle.
- Assert reset during WAIT → dmem_req and mem_stall drop immediately; first instruction after release retires normally.
